// File: rtl/exec_ctrl.sv
// Execution controller for the accumulator CPU.
// It gates the CPU datapath enable to provide run and single-step modes, and it detects HLT.
// After each halt or step it streams a state dump (PC, ACC, cycle count and the first data-memory
// words) over a valid/ready word interface.
module exec_ctrl #(
  parameter int unsigned OPBTS      = 5,
  parameter int unsigned DBTS       = 16,
  parameter int unsigned PCBTS      = 11,
  parameter int unsigned DABTS      = 11,
  parameter int unsigned DUMP_WORDS = 8,
  parameter logic [OPBTS-1:0] HLT_OP   = '0,
  parameter logic [7:0]       CMD_RUN  = 8'h63,
  parameter logic [7:0]       CMD_STEP = 8'h73,
  parameter logic [7:0]       CMD_CLR  = 8'h72
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_cmd,
  input  logic             i_cmd_valid,
  input  logic [OPBTS-1:0] i_op_code,
  input  logic [PCBTS-1:0] i_pc,
  input  logic [DBTS-1:0]  i_acc,
  output logic             o_cpu_en,
  output logic             o_cpu_rst,
  output logic [DABTS-1:0] o_dmem_addr,
  output logic             o_dmem_rd,
  input  logic [DBTS-1:0]  i_dmem_data,
  output logic [DBTS-1:0]  o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_halted,
  output logic [DBTS-1:0]  o_cycles
);

  localparam logic [DABTS-1:0] LastAddr = DABTS'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle, StRun, StStep, StDumpPc, StDumpAcc, StDumpCyc, StMemRd, StMemSend
  } state_e;

  state_e           state_q, state_d;
  logic [DBTS-1:0]  cycles_q, cycles_d;
  logic             halted_q, halted_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             dmem_rd_q, dmem_rd_d;
  logic [DABTS-1:0] dmem_addr_q, dmem_addr_d;
  logic [DBTS-1:0]  tx_data_q, tx_data_d;
  // High during the first MEM_SEND cycle, when read data comes straight from the RAM port.
  logic             mem_first_q, mem_first_d;
  logic             is_hlt;
  logic             tx_done;

  assign is_hlt  = (i_op_code == HLT_OP);
  assign tx_done = i_tx_ready;

  // State and datapath registers; reset aborts any run or dump immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cycles_q    <= '0;
      halted_q    <= 1'b0;
      cpu_rst_q   <= 1'b0;
      dmem_rd_q   <= 1'b0;
      dmem_addr_q <= '0;
      tx_data_q   <= '0;
      mem_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      halted_q    <= halted_d;
      cpu_rst_q   <= cpu_rst_d;
      dmem_rd_q   <= dmem_rd_d;
      dmem_addr_q <= dmem_addr_d;
      tx_data_q   <= tx_data_d;
      mem_first_q <= mem_first_d;
    end
  end

  // Next-state logic; each dump word is captured on the edge that enters its state.
  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    halted_d    = halted_q;
    cpu_rst_d   = 1'b0;
    dmem_rd_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    tx_data_d   = tx_data_q;
    mem_first_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          if (i_cmd == CMD_RUN && !halted_q) begin
            state_d = StRun;
          end else if (i_cmd == CMD_STEP && !halted_q) begin
            state_d = StStep;
          end else if (i_cmd == CMD_CLR) begin
            cpu_rst_d = 1'b1;
            cycles_d  = '0;
            halted_d  = 1'b0;
          end
        end
      end
      StRun: begin
        if (is_hlt) begin
          halted_d  = 1'b1;
          state_d   = StDumpPc;
          tx_data_d = DBTS'(i_pc);
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + DBTS'(1);
        end
      end
      StStep: begin
        if (is_hlt) begin
          halted_d = 1'b1;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + DBTS'(1);
        end
        state_d   = StDumpPc;
        tx_data_d = DBTS'(i_pc);
      end
      StDumpPc: begin
        if (tx_done) begin
          state_d   = StDumpAcc;
          tx_data_d = i_acc;
        end
      end
      StDumpAcc: begin
        if (tx_done) begin
          state_d   = StDumpCyc;
          tx_data_d = cycles_q;
        end
      end
      StDumpCyc: begin
        if (tx_done) begin
          state_d     = StMemRd;
          dmem_addr_d = '0;
          dmem_rd_d   = 1'b1;
        end
      end
      StMemRd: begin
        state_d     = StMemSend;
        mem_first_d = 1'b1;
      end
      StMemSend: begin
        if (mem_first_q) begin
          tx_data_d = i_dmem_data;
        end
        if (tx_done) begin
          if (dmem_addr_q == LastAddr) begin
            state_d = StIdle;
          end else begin
            state_d     = StMemRd;
            dmem_addr_d = dmem_addr_q + DABTS'(1);
            dmem_rd_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; the first memory-word cycle forwards RAM data before it is held.
  always_comb begin
    o_cpu_en    = (state_q == StRun || state_q == StStep) && !is_hlt;
    o_tx_valid  = (state_q == StDumpPc) || (state_q == StDumpAcc) ||
                  (state_q == StDumpCyc) || (state_q == StMemSend);
    o_tx_data   = (state_q == StMemSend && mem_first_q) ? i_dmem_data : tx_data_q;
    o_busy      = (state_q != StIdle);
    o_halted    = halted_q;
    o_cycles    = cycles_q;
    o_cpu_rst   = cpu_rst_q;
    o_dmem_rd   = dmem_rd_q;
    o_dmem_addr = dmem_addr_q;
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed command vectors plus hand-written
// sequences for run-to-halt, backpressure and reset during a dump.
module tb_exec_ctrl;

  localparam logic [7:0] CmdRun  = 8'h63;
  localparam logic [7:0] CmdStep = 8'h73;
  localparam logic [7:0] CmdClr  = 8'h72;
  localparam logic [4:0] OpHlt   = 5'd0;
  localparam logic [4:0] OpLdi   = 5'd1;
  localparam logic [4:0] OpAdd   = 5'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        cmd_valid = 1'b0;
  logic [4:0]  op = OpLdi;
  logic [10:0] pc = '0;
  logic [15:0] acc = '0;
  logic        cpu_en, cpu_rst, dmem_rd, tx_valid, busy, halted;
  logic [10:0] dmem_addr;
  logic [15:0] dmem_data = '0;
  logic [15:0] tx_data, cycles;
  logic        tx_ready = 1'b1;

  always #5 clk = ~clk;

  exec_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd       (cmd),
    .i_cmd_valid (cmd_valid),
    .i_op_code   (op),
    .i_pc        (pc),
    .i_acc       (acc),
    .o_cpu_en    (cpu_en),
    .o_cpu_rst   (cpu_rst),
    .o_dmem_addr (dmem_addr),
    .o_dmem_rd   (dmem_rd),
    .i_dmem_data (dmem_data),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_busy      (busy),
    .o_halted    (halted),
    .o_cycles    (cycles)
  );

  // Data RAM model: registered read, data valid the cycle after the strobe.
  logic [15:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i) * 16'h0111;
  always @(posedge clk) if (dmem_rd) dmem_data <= mem[dmem_addr[2:0]];

  // Mid-cycle monitor: handshakes, read addresses, enable and soft-reset cycles.
  logic [15:0] words [$];
  logic [10:0] addrs [$];
  int en_cnt = 0;
  int rst_cnt = 0;
  always @(negedge clk) begin
    if (tx_valid && tx_ready) words.push_back(tx_data);
    if (dmem_rd) addrs.push_back(dmem_addr);
    if (cpu_en) en_cnt++;
    if (cpu_rst) rst_cnt++;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk); #1;
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk({name, " idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_dump(input string name, input int bw, input int ba,
                            input logic [10:0] epc, input logic [15:0] eacc,
                            input logic [15:0] ecyc);
    logic [15:0] exp [11];
    exp[0] = {5'b0, epc};
    exp[1] = eacc;
    exp[2] = ecyc;
    for (int i = 0; i < 8; i++) exp[3+i] = mem[i];
    chk({name, " nwords"}, words.size() - bw, 32'd11);
    for (int i = 0; i < 11; i++)
      if (bw + i < words.size())
        chk($sformatf("%s word%0d", name, i), {16'd0, words[bw+i]}, {16'd0, exp[i]});
    chk({name, " naddr"}, addrs.size() - ba, 32'd8);
    for (int i = 0; i < 8; i++)
      if (ba + i < addrs.size())
        chk($sformatf("%s addr%0d", name, i), {21'd0, addrs[ba+i]}, i);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [4:0]  op;
    logic [10:0] pc;
    logic [15:0] acc;
    int          en;
    int          rstp;
    logic [15:0] cyc;
    logic        halt;
    int          nwords;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int bw, ba, be, br;

    // Starts after a run to HLT: halted=1, cycles=3.
    vecs[0]  = '{CmdRun,  OpAdd, 11'h001, 16'h0001, 0, 0, 16'd3, 1'b1, 0};
    vecs[1]  = '{CmdStep, OpAdd, 11'h001, 16'h0001, 0, 0, 16'd3, 1'b1, 0};
    vecs[2]  = '{CmdClr,  OpAdd, 11'h001, 16'h0001, 0, 1, 16'd0, 1'b0, 0};
    vecs[3]  = '{CmdStep, OpAdd, 11'h010, 16'h1234, 1, 0, 16'd1, 1'b0, 11};
    vecs[4]  = '{CmdStep, OpAdd, 11'h7FF, 16'hFFFF, 1, 0, 16'd2, 1'b0, 11};
    vecs[5]  = '{8'h41,   OpAdd, 11'h7FF, 16'hFFFF, 0, 0, 16'd2, 1'b0, 0};
    vecs[6]  = '{CmdStep, OpHlt, 11'h3C3, 16'h8001, 0, 0, 16'd2, 1'b1, 11};
    vecs[7]  = '{CmdClr,  OpHlt, 11'h3C3, 16'h8001, 0, 1, 16'd0, 1'b0, 0};
    vecs[8]  = '{CmdRun,  OpHlt, 11'h004, 16'h00FF, 0, 0, 16'd0, 1'b1, 11};
    vecs[9]  = '{CmdClr,  OpLdi, 11'h004, 16'h00FF, 0, 1, 16'd0, 1'b0, 0};
    vecs[10] = '{CmdStep, OpLdi, 11'h155, 16'h4242, 1, 0, 16'd1, 1'b0, 11};

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b1;
    #1;
    chk("rst cpu_en",   {31'd0, cpu_en},   32'd0);
    chk("rst cpu_rst",  {31'd0, cpu_rst},  32'd0);
    chk("rst dmem_rd",  {31'd0, dmem_rd},  32'd0);
    chk("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst tx_data",  {16'd0, tx_data},  32'd0);
    chk("rst addr",     {21'd0, dmem_addr}, 32'd0);
    chk("rst halted",   {31'd0, halted},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst busy",   {31'd0, busy},   32'd0);
    chk("post-rst cycles", {16'd0, cycles}, 32'd0);

    // RUN with LDI, ADD, ADD, HLT one per cycle.
    bw = words.size(); ba = addrs.size(); be = en_cnt;
    pc = 11'h123; acc = 16'hBEEF; op = OpLdi;
    send_cmd(CmdRun);
    @(posedge clk); #1 op = OpAdd;
    @(posedge clk); #1 op = OpAdd;
    @(posedge clk); #1 op = OpHlt;
    wait_idle("run");
    chk("run en",     en_cnt - be, 32'd3);
    chk("run halted", {31'd0, halted}, 32'd1);
    chk("run cycles", {16'd0, cycles}, 32'd3);
    check_dump("run", bw, ba, 11'h123, 16'hBEEF, 16'd3);

    // Directed command vectors.
    for (int v = 0; v < 11; v++) begin
      bw = words.size(); ba = addrs.size(); be = en_cnt; br = rst_cnt;
      op = vecs[v].op; pc = vecs[v].pc; acc = vecs[v].acc;
      send_cmd(vecs[v].cmd);
      wait_idle($sformatf("v%0d", v));
      chk($sformatf("v%0d en", v),     en_cnt - be, vecs[v].en);
      chk($sformatf("v%0d cpu_rst", v), rst_cnt - br, vecs[v].rstp);
      chk($sformatf("v%0d cycles", v), {16'd0, cycles}, {16'd0, vecs[v].cyc});
      chk($sformatf("v%0d halted", v), {31'd0, halted}, {31'd0, vecs[v].halt});
      if (vecs[v].nwords == 0)
        chk($sformatf("v%0d nwords", v), words.size() - bw, 32'd0);
      else
        check_dump($sformatf("v%0d", v), bw, ba, vecs[v].pc, vecs[v].acc, vecs[v].cyc);
    end

    // Backpressure on the ACC word, with a RUN command dropped mid-dump.
    bw = words.size(); ba = addrs.size(); be = en_cnt;
    op = OpAdd; pc = 11'h2AA; acc = 16'h5A5A;
    send_cmd(CmdStep);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp valid%0d", k), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("bp data%0d", k),  {16'd0, tx_data},  32'h5A5A);
      cmd = CmdRun;
      cmd_valid = (k == 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle("bp");
    chk("bp en", en_cnt - be, 32'd1);
    chk("bp cycles", {16'd0, cycles}, 32'd2);
    check_dump("bp", bw, ba, 11'h2AA, 16'h5A5A, 16'd2);

    // Reset while sending MEM[4], then a fresh STEP dumps from PC.
    bw = words.size();
    op = OpAdd; pc = 11'h0AB; acc = 16'h0001;
    send_cmd(CmdStep);
    for (int i = 0; i < 100; i++) begin
      if (tx_valid && dmem_addr == 11'd4) break;
      @(posedge clk); #1;
    end
    chk("abort reached mem4", {21'd0, dmem_addr}, 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("abort tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort busy",     {31'd0, busy},     32'd0);
    chk("abort cycles",   {16'd0, cycles},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort nwords", words.size() - bw, 32'd7);
    bw = words.size(); ba = addrs.size();
    pc = 11'h055; acc = 16'h0F0F;
    send_cmd(CmdStep);
    wait_idle("restart");
    chk("restart cycles", {16'd0, cycles}, 32'd1);
    check_dump("restart", bw, ba, 11'h055, 16'h0F0F, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
